// File: rtl/microc_ctrl.sv
// microc_ctrl: instruction decode and sequencing for the microc datapath.
// Decodes opcode/zero into datapath controls. It also provides a run/stall
// gate, return-stack push/pop with occupancy tracking, and HALT/ERROR states.
//
// Ports:
//   clk, reset (async, active-low)
//   opcode, zero, run_en            : instruction, zero flag, execute gate
//   s_inc, s_inm, we, wez, alu_op   : datapath controls (Mealy in RUN)
//   pc_en, push, pop, s_stack       : PC load and return-stack controls
//   sp                              : return-stack occupancy
//   halted, error                   : terminal-state flags
module microc_ctrl #(
    parameter int unsigned OPW            = 6,
    parameter int unsigned ALUW           = 3,
    parameter int unsigned STACK_DEPTH    = 4,
    parameter int unsigned ERR_ON_ILLEGAL = 1,
    localparam int unsigned SPW           = $clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero,
    input  logic            run_en,
    output logic            s_inc,
    output logic            s_inm,
    output logic            we,
    output logic            wez,
    output logic [ALUW-1:0] alu_op,
    output logic            pc_en,
    output logic            push,
    output logic            pop,
    output logic            s_stack,
    output logic [SPW-1:0]  sp,
    output logic            halted,
    output logic            error
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [5:0]     op;
    logic           illegal;
    logic           fault;
    logic           halt_op;

    assign op = opcode[5:0];

    // State and stack-pointer registers; reset forces every output to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            sp_q    <= '0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
        end
    end

    // Decode, stall gating and next-state selection.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        s_inc   = 1'b0;
        s_inm   = 1'b0;
        we      = 1'b0;
        wez     = 1'b0;
        alu_op  = '0;
        pc_en   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        s_stack = 1'b0;
        illegal = 1'b0;
        fault   = 1'b0;
        halt_op = 1'b0;

        case (state_q)
            ST_INIT: state_d = ST_RUN;
            ST_RUN: begin
                case (op[5:3])
                    3'b000, 3'b010: begin
                        s_inm  = op[4];
                        alu_op = opcode[ALUW-1:0];
                        s_inc  = 1'b1;
                        we     = 1'b1;
                        // Operation 0 is a pass-through load; it leaves the flag alone.
                        wez    = |opcode[ALUW-1:0];
                    end
                    3'b100: s_inc = 1'b0;
                    3'b101: s_inc = op[0] ? zero : ~zero;
                    3'b110: begin
                        if (op[2:0] == 3'b000) begin
                            if (sp_q == SPW'(STACK_DEPTH)) fault = 1'b1;
                            else                           push  = 1'b1;
                        end else if (op[2:0] == 3'b001) begin
                            if (sp_q == '0) begin
                                fault = 1'b1;
                            end else begin
                                pop     = 1'b1;
                                s_stack = 1'b1;
                            end
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    3'b111: begin
                        if (op[2:0] == 3'b000)      s_inc   = 1'b1;
                        else if (op[2:0] == 3'b111) halt_op = 1'b1;
                        else                        illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase

                if (illegal) begin
                    if (ERR_ON_ILLEGAL != 0) fault = 1'b1;
                    else                     s_inc = 1'b1;
                end

                pc_en = run_en & ~fault & ~halt_op;

                if (run_en) begin
                    if (fault)        state_d = ST_ERROR;
                    else if (halt_op) state_d = ST_HALT;
                    if (push) sp_d = sp_q + SPW'(1);
                    if (pop)  sp_d = sp_q - SPW'(1);
                end else begin
                    // Stalled: show the decode but suppress every side effect.
                    we   = 1'b0;
                    wez  = 1'b0;
                    push = 1'b0;
                    pop  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign sp     = sp_q;
    assign halted = (state_q == ST_HALT);
    assign error  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_microc_ctrl.sv
// Bench for microc_ctrl: two instances (illegal->ERROR and illegal->NOP)
// driven by shared inputs, checked against a behavioural reference model.
module tb_microc_ctrl;

    localparam logic [5:0] OP_NOP  = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_CALL = 6'b110000;
    localparam logic [5:0] OP_RET  = 6'b110001;
    localparam logic [5:0] OP_SBI  = 6'b010011;

    localparam int K_ALU = 0, K_J = 1, K_JZ = 2, K_JNZ = 3, K_CALL = 4,
                   K_RET = 5, K_NOP = 6, K_HALT = 7, K_ILL = 8;

    typedef struct packed {
        logic       s_inc, s_inm, we, wez;
        logic [2:0] alu_op;
        logic       pc_en, push, pop, s_stack;
        logic [2:0] sp;
        logic       halted, error;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        logic       en;
        outs_t      exp;
    } vec_t;

    logic       clk, reset, zero, run_en;
    logic [5:0] opcode;

    logic       a_s_inc, a_s_inm, a_we, a_wez, a_pc_en, a_push, a_pop, a_s_stack, a_halted, a_error;
    logic [2:0] a_alu_op, a_sp;
    logic       b_s_inc, b_s_inm, b_we, b_wez, b_pc_en, b_push, b_pop, b_s_stack, b_halted, b_error;
    logic [2:0] b_alu_op, b_sp;

    int n_cmp = 0;
    int n_mis = 0;
    int mst[2];
    int msp[2];

    microc_ctrl #(.ERR_ON_ILLEGAL(1)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .run_en(run_en),
        .s_inc(a_s_inc), .s_inm(a_s_inm), .we(a_we), .wez(a_wez), .alu_op(a_alu_op),
        .pc_en(a_pc_en), .push(a_push), .pop(a_pop), .s_stack(a_s_stack), .sp(a_sp),
        .halted(a_halted), .error(a_error)
    );

    microc_ctrl #(.ERR_ON_ILLEGAL(0)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .run_en(run_en),
        .s_inc(b_s_inc), .s_inm(b_s_inm), .we(b_we), .wez(b_wez), .alu_op(b_alu_op),
        .pc_en(b_pc_en), .push(b_push), .pop(b_pop), .s_stack(b_s_stack), .sp(b_sp),
        .halted(b_halted), .error(b_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic outs_t get_o(input int i);
        outs_t o;
        if (i == 0)
            o = {a_s_inc, a_s_inm, a_we, a_wez, a_alu_op, a_pc_en, a_push, a_pop,
                 a_s_stack, a_sp, a_halted, a_error};
        else
            o = {b_s_inc, b_s_inm, b_we, b_wez, b_alu_op, b_pc_en, b_push, b_pop,
                 b_s_stack, b_sp, b_halted, b_error};
        return o;
    endfunction

    function automatic outs_t mk(input logic inc, input logic inm, input logic w,
                                 input logic wz, input logic [2:0] alu, input logic pc);
        outs_t o = '0;
        o.s_inc = inc; o.s_inm = inm; o.we = w; o.wez = wz; o.alu_op = alu; o.pc_en = pc;
        return o;
    endfunction

    // Instruction classification by mnemonic pattern.
    function automatic int kind(input logic [5:0] op);
        casez (op)
            6'b0?0???: return K_ALU;
            6'b100???: return K_J;
            6'b101??0: return K_JZ;
            6'b101??1: return K_JNZ;
            6'b110000: return K_CALL;
            6'b110001: return K_RET;
            6'b111000: return K_NOP;
            6'b111111: return K_HALT;
            default:   return K_ILL;
        endcase
    endfunction

    // Reference model: state 0=INIT 1=RUN 2=HALT 3=ERROR, sp as an integer count.
    task automatic model(input int st, input int sp, input logic [5:0] op, input logic z,
                         input logic en, input bit ill_err,
                         output outs_t e, output int nst, output int nsp);
        int k;
        bit adv;
        e = '0; nst = st; nsp = sp; adv = 0;
        e.sp = 3'(sp); e.halted = (st == 2); e.error = (st == 3);
        if (st == 0) nst = 1;
        if (st == 1) begin
            k = kind(op);
            if (k == K_ILL && !ill_err) k = K_NOP;
            case (k)
                K_ALU: begin
                    e.s_inc = 1; e.s_inm = op[4]; e.alu_op = op[2:0];
                    e.we = 1; e.wez = (op[2:0] != 3'd0); adv = 1;
                end
                K_J:   adv = 1;
                K_JZ:  begin e.s_inc = !z; adv = 1; end
                K_JNZ: begin e.s_inc = z;  adv = 1; end
                K_CALL: if (sp < 4) begin e.push = 1; adv = 1; nsp = sp + 1; end
                        else nst = 3;
                K_RET:  if (sp > 0) begin e.pop = 1; e.s_stack = 1; adv = 1; nsp = sp - 1; end
                        else nst = 3;
                K_NOP:  begin e.s_inc = 1; adv = 1; end
                K_HALT: nst = 2;
                default: nst = 3;
            endcase
            e.pc_en = adv;
            if (!en) begin
                e.we = 0; e.wez = 0; e.push = 0; e.pop = 0; e.pc_en = 0;
                nst = 1; nsp = sp;
            end
        end
    endtask

    task automatic check(input string nm, input outs_t act, input outs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h (bin %b) expected %h (bin %b)", nm, act, act, exp, exp);
        end
    endtask

    task automatic check_v(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Assert reset mid-cycle, hold across two edges, release just after an edge.
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("reset_async_a", get_o(0), '0);
        check("reset_async_b", get_o(1), '0);
        @(negedge clk);
        #1;
        check("reset_hold_a", get_o(0), '0);
        @(posedge clk);
        #1 reset = 1'b1;
        mst[0] = 0; mst[1] = 0; msp[0] = 0; msp[1] = 0;
    endtask

    // One instruction cycle: drive at negedge, compare both DUTs, advance model at posedge.
    task automatic step(input logic [5:0] op, input logic z, input logic en);
        outs_t e;
        int ns[2];
        int nsp[2];
        @(negedge clk);
        opcode = op; zero = z; run_en = en;
        #1;
        for (int i = 0; i < 2; i++) begin
            model(mst[i], msp[i], op, z, en, (i == 0), e, ns[i], nsp[i]);
            check($sformatf("step_%s op=%b z=%0b en=%0b", (i == 0) ? "a" : "b", op, z, en),
                  get_o(i), e);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            mst[i] = ns[i];
            msp[i] = nsp[i];
        end
    endtask

    initial begin
        vec_t tv[9];
        logic [5:0] rop;

        tv[0] = '{6'b010000, 1'b0, 1'b1, mk(1, 1, 1, 0, 3'b000, 1)}; // LI
        tv[1] = '{6'b000011, 1'b0, 1'b1, mk(1, 0, 1, 1, 3'b011, 1)}; // SUB reg
        tv[2] = '{6'b010010, 1'b0, 1'b1, mk(1, 1, 1, 1, 3'b010, 1)}; // ADI
        tv[3] = '{6'b101000, 1'b1, 1'b1, mk(0, 0, 0, 0, 3'b000, 1)}; // JZ taken
        tv[4] = '{6'b101000, 1'b0, 1'b1, mk(1, 0, 0, 0, 3'b000, 1)}; // JZ not taken
        tv[5] = '{6'b101001, 1'b0, 1'b1, mk(0, 0, 0, 0, 3'b000, 1)}; // JNZ taken
        tv[6] = '{6'b100101, 1'b1, 1'b1, mk(0, 0, 0, 0, 3'b000, 1)}; // J
        tv[7] = '{OP_NOP,    1'b0, 1'b1, mk(1, 0, 0, 0, 3'b000, 1)}; // NOP
        tv[8] = '{OP_SBI,    1'b0, 1'b0, mk(1, 1, 0, 0, 3'b011, 0)}; // SBI stalled

        reset = 1'b0; opcode = OP_NOP; zero = 1'b0; run_en = 1'b1;
        mst[0] = 0; mst[1] = 0; msp[0] = 0; msp[1] = 0;

        // Reset, INIT cycle, then RUN.
        do_reset();
        step(OP_NOP, 1'b0, 1'b1);
        step(OP_NOP, 1'b0, 1'b1);
        #1 check_v("run_after_reset_pc_en", a_pc_en, 1);

        // Decode vectors in RUN with an empty stack.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            opcode = tv[i].op; zero = tv[i].z; run_en = tv[i].en;
            #1;
            check($sformatf("vec%0d_a op=%b", i, tv[i].op), get_o(0), tv[i].exp);
            check($sformatf("vec%0d_b op=%b", i, tv[i].op), get_o(1), tv[i].exp);
        end

        // Fill the stack, then overflow into ERROR.
        for (int k = 1; k <= 4; k++) begin
            step(OP_CALL, 1'b0, 1'b1);
            #1 check_v($sformatf("call_sp%0d", k), a_sp, k);
        end
        step(OP_CALL, 1'b0, 1'b1);
        #1 check_v("call_overflow_err", a_error, 1);
        check_v("call_overflow_sp", a_sp, 4);
        step(OP_NOP, 1'b0, 1'b1);

        // RET on an empty stack faults.
        do_reset();
        step(OP_NOP, 1'b0, 1'b1);
        step(OP_RET, 1'b0, 1'b1);
        #1 check_v("ret_underflow_err", a_error, 1);
        check_v("ret_underflow_sp", a_sp, 0);

        // Stall during SBI with one stack entry live.
        do_reset();
        step(OP_NOP, 1'b0, 1'b1);
        step(OP_CALL, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(OP_SBI, 1'b1, 1'b0);
            #1 check_v($sformatf("stall_sp%0d", k), a_sp, 1);
        end
        step(OP_SBI, 1'b1, 1'b1);

        // Mid-run reset with a non-empty stack, then HALT.
        do_reset();
        step(OP_NOP, 1'b0, 1'b1);
        step(OP_HALT, 1'b0, 1'b1);
        #1 check_v("halt_flag", a_halted, 1);
        for (int k = 0; k < 4; k++) begin
            step(6'b010001, 1'b0, 1'b1);
            #1 check_v($sformatf("halt_pc_en%0d", k), a_pc_en, 0);
        end

        // Illegal opcode: ERROR on one instance, NOP on the other.
        do_reset();
        step(OP_NOP, 1'b0, 1'b1);
        step(6'b001000, 1'b0, 1'b1);
        #1 check_v("ill_b_no_err", b_error, 0);
        check_v("ill_a_err", a_error, 1);
        step(OP_NOP, 1'b0, 1'b1);

        // Randomized instruction streams with occasional resets.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ((mst[0] >= 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0)
                do_reset();
            case ($urandom_range(0, 7))
                0, 1, 2: rop = {1'b0, 1'($urandom_range(0, 1)), 1'b0, 3'($urandom_range(0, 7))};
                3:       rop = {3'b100, 3'($urandom_range(0, 7))};
                4:       rop = {3'b101, 3'($urandom_range(0, 7))};
                5:       rop = ($urandom_range(0, 1) != 0) ? OP_CALL : OP_RET;
                6:       rop = OP_NOP;
                default: rop = 6'($urandom_range(0, 63));
            endcase
            step(rop, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
